// File: rtl/net_arb_pkg.sv
// Shared types and constants for the network owner-switch sequencer.
// Channel order on the O side is txc, txd, rxd, rxs.
package net_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        RESET,
        SETTLE
    } state_t;

    localparam int CH_TXC = 0;
    localparam int CH_TXD = 1;
    localparam int CH_RXD = 2;
    localparam int CH_RXS = 3;

    localparam logic OWNER_T = 1'b1;
    localparam logic OWNER_U = 1'b0;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/net_owner_switch_seq_if.sv
// Control and O-side observation bundle of the owner-switch sequencer.
// The slave side is the sequencer; the master side is the control path.
interface net_owner_switch_seq_if #(
    parameter int NCH = 4
);
    logic           req_valid;
    logic           req_owner;
    logic           req_ready;
    logic [NCH-1:0] ch_tvalid;
    logic [NCH-1:0] ch_tready;
    logic [NCH-1:0] ch_tlast;
    logic [NCH-1:0] gate;
    logic           trusted;
    logic           nic_resetn;
    logic           busy;
    logic           done;
    logic           timeout_err;
    logic           err_clr;

    modport slave (
        input  req_valid, req_owner, err_clr,
        input  ch_tvalid, ch_tready, ch_tlast,
        output req_ready, gate, trusted, nic_resetn,
        output busy, done, timeout_err
    );

    modport master (
        output req_valid, req_owner, err_clr,
        output ch_tvalid, ch_tready, ch_tlast,
        input  req_ready, gate, trusted, nic_resetn,
        input  busy, done, timeout_err
    );

endinterface

// File: rtl/net_pkt_tracker.sv
// Per-channel open-packet flag: set by a non-last beat, cleared by a last
// beat or by the sequencer while the NIC is held in reset.
module net_pkt_tracker (
    input  logic S_CLK,
    input  logic S_ARESETN,
    input  logic i_hs,
    input  logic i_last,
    input  logic i_clr,
    output logic o_in_pkt
);

    logic r_in_pkt;

    always_ff @(posedge S_CLK or negedge S_ARESETN) begin
        if (!S_ARESETN) begin
            r_in_pkt <= 1'b0;
        end else if (i_clr) begin
            r_in_pkt <= 1'b0;
        end else if (i_hs) begin
            r_in_pkt <= !i_last;
        end
    end

    assign o_in_pkt = r_in_pkt;

endmodule

// File: rtl/net_owner_switch_seq.sv
// Hands the shared NIC between trusted and untrusted domains: drain open
// packets, hold NIC reset, flip the owner select, settle, release.
module net_owner_switch_seq
    import net_arb_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int RESET_OWNER   = 1
) (
    input  logic                  S_CLK,
    input  logic                  S_ARESETN,
    net_owner_switch_seq_if.slave bus
);

    localparam int CNT_MAX = max3(DRAIN_TIMEOUT, RST_CYCLES, SETTLE_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic          OWNER_RST   = (RESET_OWNER != 0) ? OWNER_T : OWNER_U;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic           r_tgt;
    logic           r_trusted;
    logic           r_err;
    logic           r_done;
    logic           r_up;
    logic           w_done_nxt;
    logic           w_err_set;
    logic           w_latch;
    logic           w_flip;
    logic           w_clr;
    logic [NCH-1:0] w_in_pkt;
    logic [NCH-1:0] w_hs;
    logic [NCH-1:0] w_gate;

    assign w_hs  = bus.ch_tvalid & bus.ch_tready & ~w_gate;
    assign w_clr = (r_state == RESET);

    for (genvar i = 0; i < NCH; i++) begin : g_trk
        net_pkt_tracker u_trk (
            .S_CLK    (S_CLK),
            .S_ARESETN(S_ARESETN),
            .i_hs     (w_hs[i]),
            .i_last   (bus.ch_tlast[i]),
            .i_clr    (w_clr),
            .o_in_pkt (w_in_pkt[i])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_set   = 1'b0;
        w_latch     = 1'b0;
        w_flip      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_owner == r_trusted) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_in_pkt == '0) begin
                    w_state_nxt = RESET;
                end else if (r_cnt == DRAIN_LAST) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = RESET;
                end
            end
            RESET: begin
                if (r_cnt == RST_LAST) begin
                    w_flip      = 1'b1;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    // Gates stay shut until the first clock after reset release.
    always_comb begin
        w_gate = '1;
        if (r_up) begin
            unique case (r_state)
                IDLE:    w_gate = '0;
                DRAIN:   w_gate = ~w_in_pkt;
                default: w_gate = '1;
            endcase
        end
    end

    always_ff @(posedge S_CLK or negedge S_ARESETN) begin
        if (!S_ARESETN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_tgt     <= OWNER_RST;
            r_trusted <= OWNER_RST;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_up      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_up    <= 1'b1;
            if (w_state_nxt != r_state || r_state == IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_latch) begin
                r_tgt <= bus.req_owner;
            end
            if (w_flip) begin
                r_trusted <= r_tgt;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.gate        = w_gate;
    assign bus.trusted     = r_trusted;
    assign bus.nic_resetn  = r_up && (r_state != RESET);
    assign bus.done        = r_done;
    assign bus.timeout_err = r_err;

endmodule

// File: tb/tb_net_owner_switch_seq.sv
// Scoreboard bench for the owner-switch sequencer: accepted requests push
// expected outcomes, a monitor pops and checks them at each done pulse.
module tb_net_owner_switch_seq;
    import net_arb_pkg::*;

    localparam int NCH = 4;
    localparam int T   = 64;
    localparam int R   = 16;
    localparam int S   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    net_owner_switch_seq_if #(.NCH(NCH)) bus ();

    net_owner_switch_seq #(
        .NCH          (NCH),
        .DRAIN_TIMEOUT(T),
        .RST_CYCLES   (R),
        .SETTLE_CYCLES(S),
        .RESET_OWNER  (1)
    ) dut (
        .S_CLK    (clk),
        .S_ARESETN(rst_n),
        .bus      (bus)
    );

    typedef struct {
        int   acc;
        int   lat;
        logic owner;
        logic err;
        int   nlow;
    } exp_t;

    exp_t           q[$];
    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    int             nlow  = 0;
    int             ndone = 0;
    logic           m_trusted = 1'b1;
    logic           m_err     = 1'b0;
    logic [NCH-1:0] m_open    = '0;
    int             m_k       = -1;
    logic           prev_t;
    bit             prev_ok   = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model works per transaction: outcome follows from whether
    // the owner changes, which packets are open, and when they will close.
    always @(negedge clk) begin : mon
        exp_t e;
        int   drain;
        if (!rst_n) begin
            prev_ok = 1'b0;
            nlow    = 0;
        end else begin
            if (prev_ok && bus.trusted !== prev_t)
                chk("gate_at_flip", bus.gate, 32'hF);
            prev_t  = bus.trusted;
            prev_ok = 1'b1;
            if (bus.busy && !bus.nic_resetn) nlow++;
            if (bus.done) begin
                ndone++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected none at cyc %0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.acc, e.lat);
                    chk("owner", bus.trusted, e.owner);
                    chk("err", bus.timeout_err, e.err);
                    chk("nic_low", nlow, e.nlow);
                end
                nlow = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
                e.acc = cyc;
                if (bus.req_owner == m_trusted) begin
                    e.lat   = 1;
                    e.owner = m_trusted;
                    e.err   = m_err;
                    e.nlow  = 0;
                end else begin
                    if (m_open == '0) drain = 1;
                    else if (m_k >= 0) drain = m_k + 2;
                    else drain = T;
                    if (m_open != '0 && m_k < 0) m_err = 1'b1;
                    e.lat     = 1 + drain + R + S;
                    e.owner   = bus.req_owner;
                    e.err     = m_err;
                    e.nlow    = R;
                    m_trusted = bus.req_owner;
                end
                q.push_back(e);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk(nm, seen, 1);
    endtask

    task automatic set_ch(int ch, logic v, logic l);
        bus.ch_tvalid[ch] = v;
        bus.ch_tready[ch] = v;
        bus.ch_tlast[ch]  = l;
    endtask

    task automatic run_seq(logic owner, int ch, int nbeats, int k, bit clr_hold);
        bit   sw;
        logic pe;
        tick(1);
        sw = (owner != m_trusted);
        pe = m_err;
        if (!sw) ch = -1;
        m_k = k;
        if (ch >= 0) begin
            set_ch(ch, 1'b1, 1'b0);
            tick(nbeats);
            set_ch(ch, 1'b0, 1'b0);
            m_open[ch] = 1'b1;
        end
        bus.req_valid = 1'b1;
        bus.req_owner = owner;
        bus.err_clr   = clr_hold;
        tick(1);
        bus.req_valid = 1'b0;
        if (sw && ch >= 0 && k == 0) set_ch(ch, 1'b1, 1'b1);
        @(negedge clk);
        if (!sw) begin
            chk("busy_match", bus.busy, 0);
            chk("gate_match", bus.gate, 0);
            chk("done_match", bus.done, 1);
        end else if (ch >= 0) begin
            chk("gate_drain", bus.gate, 32'hF & ~(32'h1 << ch));
        end else begin
            chk("gate_drain_idle", bus.gate, 32'hF);
        end
        if (sw && ch >= 0 && k >= 0) begin
            if (k > 0) begin
                tick(k);
                set_ch(ch, 1'b1, 1'b1);
            end
            tick(1);
            set_ch(ch, 1'b0, 1'b0);
            @(negedge clk);
            chk("gate_closed", bus.gate, 32'hF);
        end
        if (sw && ch >= 0 && k < 0) begin
            tick(T - 1);
            @(negedge clk);
            chk("err_pre", bus.timeout_err, clr_hold ? 1'b0 : pe);
            tick(1);
            bus.err_clr = 1'b0;
            @(negedge clk);
            chk("err_set", bus.timeout_err, 1);
        end
        bus.err_clr = 1'b0;
        if (sw) wait_done("done_seen");
        m_open = '0;
    endtask

    initial begin
        int nd0;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd0;
        int ch;
        int k;
        int mode;
        bus.req_valid = 1'b0;
        bus.req_owner = 1'b0;
        bus.err_clr   = 1'b0;
        bus.ch_tvalid = '0;
        bus.ch_tready = '0;
        bus.ch_tlast  = '0;

        repeat (3) @(negedge clk);
        chk("rst_gate", bus.gate, 32'hF);
        chk("rst_nic", bus.nic_resetn, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_trusted", bus.trusted, 1);
        chk("rst_err", bus.timeout_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("up_gate", bus.gate, 0);
        chk("up_nic", bus.nic_resetn, 1);

        run_seq(OWNER_U, -1, 0, 0, 1'b0);
        run_seq(OWNER_T, CH_TXD, 3, 20, 1'b0);
        run_seq(OWNER_U, CH_RXD, 1, -1, 1'b0);

        tick(1);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        chk("err_clr", bus.timeout_err, 0);

        run_seq(OWNER_T, CH_RXD, 1, -1, 1'b1);
        run_seq(OWNER_T, -1, 0, 0, 1'b0);

        tick(1);
        bus.req_valid = 1'b1;
        bus.req_owner = OWNER_U;
        tick(1);
        bus.req_valid = 1'b0;
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("arst_trusted", bus.trusted, 1);
        chk("arst_gate", bus.gate, 32'hF);
        chk("arst_nic", bus.nic_resetn, 0);
        chk("arst_busy", bus.busy, 0);
        q.delete();
        m_trusted = 1'b1;
        m_err     = 1'b0;
        m_open    = '0;
        tick(2);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_gate", bus.gate, 0);
        chk("rel_nic", bus.nic_resetn, 1);
        chk("rel_busy", bus.busy, 0);
        chk("rel_trusted", bus.trusted, 1);

        nd0 = ndone;
        tick(1);
        bus.req_valid = 1'b1;
        bus.req_owner = OWNER_U;
        wait_done("held_done1");
        tick(1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("held_done2", bus.done, 1);
        tick(3);
        chk("held_ndone", ndone - nd0, 2);
        chk("held_q", q.size(), 0);

        for (int it = 0; it < 10; it++) begin
            mode = $urandom_range(0, 3);
            ch   = $urandom_range(CH_TXC, CH_RXS);
            k    = $urandom_range(0, 40);
            if (mode == 0) ch = -1;
            if (mode == 3) k = -1;
            run_seq(1'($urandom_range(0, 1)), ch, $urandom_range(1, 3), k, 1'b0);
            tick($urandom_range(0, 3));
        end

        tick(3);
        chk("final_q", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
